// File: rtl/epc_pkg.sv
// rtl/epc_pkg.sv - epc_stack shared types, Mode_Set encoding and defaults (EPC_MODE_SAVE_EN)
package epc_pkg;

  localparam int EPC_DEPTH = 4;
  localparam int EPC_PC_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    FLUSH = 2'd2
  } epc_state_e;

  localparam logic [1:0] MS_HOLD = 2'b00;
  localparam logic [1:0] MS_M00  = 2'b01;
  localparam logic [1:0] MS_M01  = 2'b10;
  localparam logic [1:0] MS_CLRK = 2'b11;

`ifdef EPC_MODE_SAVE_EN
  localparam int EPC_MODE_W = 2;
  typedef struct packed {
    logic [EPC_PC_W-1:0] pc;
    logic [1:0]          mode;
  } epc_entry_t;
`else
  localparam int EPC_MODE_W = 0;
  typedef struct packed {
    logic [EPC_PC_W-1:0] pc;
  } epc_entry_t;
`endif

  // Saved pre-exception mode -> monitor Mode_Set command.
  function automatic logic [1:0] mode_map(input logic [1:0] m);
    case (m)
      2'b00:   return MS_M00;
      2'b01:   return MS_M01;
      default: return MS_CLRK;
    endcase
  endfunction

endpackage

// File: rtl/epc_lifo.sv
// rtl/epc_lifo.sv - saved-PC LIFO storage with occupancy and full/empty flags
module epc_lifo
  import epc_pkg::*;
#(
  parameter int DEPTH = EPC_DEPTH,
  parameter int W     = EPC_PC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           top_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign full     = (level == LVL_MAX);
  assign empty    = (level == '0);
  assign wr_idx   = level[AW-1:0];
  // When full the low bits wrap to 0, so top_idx lands on DEPTH-1.
  assign top_idx  = wr_idx - 1'b1;
  assign top_data = mem[top_idx];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 level <= '0;
    else if (push && !full)   level <= level + 1'b1;
    else if (pop && !empty)   level <= level - 1'b1;
  end

endmodule

// File: rtl/epc_stack.sv
// rtl/epc_stack.sv - exception-return unit: EPC LIFO, return FSM and redirect (EPC_MODE_SAVE_EN)
module epc_stack
  import epc_pkg::*;
#(
  parameter int DEPTH = EPC_DEPTH,
  parameter int PC_W  = EPC_PC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   store_current,
  input  logic [PC_W-1:0]        cur_pc,
  input  logic [1:0]             cur_mode,
  input  logic                   ret_req,
  output logic                   ret_j,
  output logic [PC_W-1:0]        ret_pc,
  output logic [1:0]             mode_set,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   unf
);

  localparam int EW = PC_W + EPC_MODE_W;

  epc_state_e    state;
  logic [EW-1:0] push_data;
  logic [EW-1:0] top_data;
  logic [1:0]    pop_mode;
  logic          full;
  logic          empty;
  logic          ret_ok;
  logic          pop_go;

`ifdef EPC_MODE_SAVE_EN
  assign push_data = {cur_pc, cur_mode};
  assign pop_mode  = mode_map(top_data[1:0]);
`else
  logic unused_cur_mode;
  assign unused_cur_mode = ^cur_mode;
  assign push_data       = cur_pc;
  assign pop_mode        = MS_CLRK;
`endif

  // An exception in the same cycle squashes the return instruction.
  assign ret_ok = ret_req && !store_current && (state == IDLE);
  assign pop_go = ret_ok && !empty;

  epc_lifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_lifo (
    .clk       (clk),
    .rst       (rst),
    .push      (store_current),
    .pop       (pop_go),
    .push_data (push_data),
    .top_data  (top_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ret_j    <= 1'b0;
      ret_pc   <= '0;
      mode_set <= MS_HOLD;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      ret_j    <= pop_go;
      mode_set <= pop_go ? pop_mode : MS_HOLD;
      unf      <= ret_ok && empty;
      if (store_current && full) ovf <= 1'b1;
      if (pop_go) ret_pc <= top_data[EW-1 -: PC_W];
      unique case (state)
        IDLE:    if (pop_go) state <= POP;
        POP:     state <= FLUSH;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epc_stack.sv
// tb/tb_epc_stack.sv - self-checking bench for epc_stack against a queue-based model
module tb_epc_stack;

  localparam int DEPTH = 4;
  localparam int PC_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              store_current = 1'b0;
  logic [PC_W-1:0]   cur_pc = '0;
  logic [1:0]        cur_mode = '0;
  logic              ret_req = 1'b0;
  logic              ret_j;
  logic [PC_W-1:0]   ret_pc;
  logic [1:0]        mode_set;
  logic [2:0]        level;
  logic              ovf;
  logic              unf;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: plain LIFO of saved (pc, mode) plus return blackout count.
  logic [PC_W-1:0] m_pc[$];
  logic [1:0]      m_md[$];
  bit              m_ovf;
  int              m_block;
  bit              e_ret_j;
  bit              e_unf;
  logic [PC_W-1:0] e_pc;
  logic [1:0]      e_ms;

  epc_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .store_current (store_current),
    .cur_pc        (cur_pc),
    .cur_mode      (cur_mode),
    .ret_req       (ret_req),
    .ret_j         (ret_j),
    .ret_pc        (ret_pc),
    .mode_set      (mode_set),
    .level         (level),
    .ovf           (ovf),
    .unf           (unf)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_mode(input logic [1:0] m);
`ifdef EPC_MODE_SAVE_EN
    if (m == 2'b00) return 2'b01;
    if (m == 2'b01) return 2'b10;
    return 2'b11;
`else
    return (m == 2'b00 || m != 2'b00) ? 2'b11 : 2'b11;
`endif
  endfunction

  task automatic model_clear();
    m_pc.delete();
    m_md.delete();
    m_ovf   = 0;
    m_block = 0;
    e_ret_j = 0;
    e_unf   = 0;
    e_pc    = '0;
    e_ms    = 2'b00;
  endtask

  // Apply one cycle of inputs, advance the model and the DUT, sample #1 after the edge.
  task automatic tick(input bit sc, input logic [PC_W-1:0] pc, input logic [1:0] md, input bit rr);
    store_current = sc;
    cur_pc        = pc;
    cur_mode      = md;
    ret_req       = rr;
    e_ret_j = 0;
    e_unf   = 0;
    e_ms    = 2'b00;
    if (sc) begin
      if (m_pc.size() < DEPTH) begin
        m_pc.push_back(pc);
        m_md.push_back(md);
      end else begin
        m_ovf = 1;
      end
    end else if (rr && m_block == 0) begin
      if (m_pc.size() == 0) begin
        e_unf = 1;
      end else begin
        e_pc    = m_pc.pop_back();
        e_ms    = exp_mode(m_md.pop_back());
        e_ret_j = 1;
        m_block = 3;
      end
    end
    if (m_block > 0) m_block--;
    @(posedge clk);
    #1;
    store_current = 0;
    ret_req       = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    store_current = 0;
    ret_req = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({ret_j, ret_pc, mode_set, level, ovf, unf} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got j=%0b pc=%0h ms=%0b lvl=%0d ovf=%0b unf=%0b want all 0",
               ret_j, ret_pc, mode_set, level, ovf, unf);
    end
    model_clear();
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    tick(1, 16'h1234, 2'b00, 0);
    n_chk++;
    if (level !== 3'd1) begin n_err++; $display("FAIL single_level_push: got %0d want 1", level); end
    tick(0, '0, 2'b00, 1);
    n_chk++;
    if (ret_j !== 1'b1 || ret_pc !== 16'h1234) begin
      n_err++; $display("FAIL single_redirect: got j=%0b pc=%0h want j=1 pc=1234", ret_j, ret_pc);
    end
    n_chk++;
    if (mode_set !== exp_mode(2'b00) || level !== 3'd0) begin
      n_err++; $display("FAIL single_mode_level: got ms=%0b lvl=%0d want ms=%0b lvl=0", mode_set, level, exp_mode(2'b00));
    end
    tick(0, '0, 2'b00, 0);
    n_chk++;
    if (ret_j !== 1'b0 || mode_set !== 2'b00) begin
      n_err++; $display("FAIL single_one_cycle: got j=%0b ms=%0b want 0/00", ret_j, mode_set);
    end
  endtask

  task automatic test_nested();
    logic [PC_W-1:0] want [3];
    want[0] = 16'h0300; want[1] = 16'h0200; want[2] = 16'h0100;
    do_reset();
    tick(1, 16'h0100, 2'b01, 0);
    tick(1, 16'h0200, 2'b10, 0);
    tick(1, 16'h0300, 2'b00, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, '0, 2'b00, 1);
      n_chk++;
      if (ret_j !== 1'b1 || ret_pc !== want[k] || mode_set !== e_ms) begin
        n_err++; $display("FAIL nested_pop%0d: got j=%0b pc=%0h ms=%0b want j=1 pc=%0h ms=%0b",
                          k, ret_j, ret_pc, mode_set, want[k], e_ms);
      end
      tick(0, '0, 2'b00, 0);
      tick(0, '0, 2'b00, 0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 16'hA000 + 16'(i), 2'b00, 0);
    n_chk++;
    if (ovf !== 1'b1 || level !== 3'd4) begin
      n_err++; $display("FAIL overflow_flag: got ovf=%0b lvl=%0d want ovf=1 lvl=4", ovf, level);
    end
    for (int k = 0; k < 4; k++) begin
      tick(0, '0, 2'b00, 1);
      n_chk++;
      if (ret_j !== 1'b1 || ret_pc !== 16'hA003 - 16'(k)) begin
        n_err++; $display("FAIL overflow_pop%0d: got j=%0b pc=%0h want j=1 pc=%0h", k, ret_j, ret_pc, 16'hA003 - 16'(k));
      end
      tick(0, '0, 2'b00, 0);
      tick(0, '0, 2'b00, 0);
    end
    n_chk++;
    if (ovf !== 1'b1 || level !== 3'd0) begin
      n_err++; $display("FAIL overflow_sticky: got ovf=%0b lvl=%0d want ovf=1 lvl=0", ovf, level);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    tick(0, '0, 2'b00, 1);
    n_chk++;
    if (unf !== 1'b1 || ret_j !== 1'b0) begin
      n_err++; $display("FAIL underflow_pulse: got unf=%0b j=%0b want unf=1 j=0", unf, ret_j);
    end
    tick(0, '0, 2'b00, 0);
    n_chk++;
    if (unf !== 1'b0 || ret_j !== 1'b0) begin
      n_err++; $display("FAIL underflow_width: got unf=%0b j=%0b want 0/0", unf, ret_j);
    end
  endtask

  task automatic test_collision_flush();
    do_reset();
    tick(1, 16'h0111, 2'b01, 0);
    tick(1, 16'h0222, 2'b10, 1);
    n_chk++;
    if (level !== 3'd2 || ret_j !== 1'b0 || unf !== 1'b0) begin
      n_err++; $display("FAIL collision: got lvl=%0d j=%0b unf=%0b want lvl=2 j=0 unf=0", level, ret_j, unf);
    end
    tick(0, '0, 2'b00, 1);
    n_chk++;
    if (ret_j !== 1'b1 || ret_pc !== 16'h0222) begin
      n_err++; $display("FAIL collision_pop: got j=%0b pc=%0h want j=1 pc=222", ret_j, ret_pc);
    end
    tick(0, '0, 2'b00, 1);
    tick(0, '0, 2'b00, 1);
    n_chk++;
    if (ret_j !== 1'b0 || level !== 3'd1) begin
      n_err++; $display("FAIL flush_ignore: got j=%0b lvl=%0d want j=0 lvl=1", ret_j, level);
    end
    tick(0, '0, 2'b00, 1);
    n_chk++;
    if (ret_j !== 1'b1 || ret_pc !== 16'h0111 || mode_set !== exp_mode(2'b01)) begin
      n_err++; $display("FAIL after_flush_pop: got j=%0b pc=%0h ms=%0b want j=1 pc=111 ms=%0b",
                        ret_j, ret_pc, mode_set, exp_mode(2'b01));
    end
  endtask

  task automatic test_reset_mid_pop();
    do_reset();
    tick(1, 16'h0BEE, 2'b01, 0);
    tick(0, '0, 2'b00, 1);
    n_chk++;
    if (ret_j !== 1'b1) begin n_err++; $display("FAIL midpop_setup: got j=%0b want 1", ret_j); end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({ret_j, ret_pc, mode_set, level, ovf, unf} !== '0) begin
      n_err++; $display("FAIL midpop_async_clear: got j=%0b pc=%0h ms=%0b lvl=%0d want all 0",
                        ret_j, ret_pc, mode_set, level);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      tick(0, '0, 2'b00, 0);
      n_chk++;
      if (ret_j !== 1'b0 || mode_set !== 2'b00) begin
        n_err++; $display("FAIL midpop_no_redirect%0d: got j=%0b ms=%0b want 0/00", i, ret_j, mode_set);
      end
    end
  endtask

  task automatic test_random();
    bit              sc;
    bit              rr;
    logic [PC_W-1:0] pc;
    logic [1:0]      md;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      sc = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 1) == 0);
      pc = PC_W'($urandom);
      md = 2'($urandom_range(0, 3));
      tick(sc, pc, md, rr);
      n_chk++;
      if (ret_j !== e_ret_j || mode_set !== e_ms || unf !== e_unf ||
          level !== 3'(m_pc.size()) || ovf !== m_ovf || (e_ret_j && ret_pc !== e_pc)) begin
        n_err++;
        $display("FAIL random_%0d: got j=%0b pc=%0h ms=%0b unf=%0b lvl=%0d ovf=%0b want j=%0b pc=%0h ms=%0b unf=%0b lvl=%0d ovf=%0b",
                 i, ret_j, ret_pc, mode_set, unf, level, ovf,
                 e_ret_j, e_pc, e_ms, e_unf, m_pc.size(), m_ovf);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_nested();
    test_overflow();
    test_underflow();
    test_collision_flush();
    test_reset_mid_pop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
